// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if #(
  parameter int WIDTH = 64
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues variable-latency data-memory accesses, stalls upstream while waiting, drives MEM/WB.
// Optional MEM_ALIGN_CHECK_EN: misaligned (addr[2:0]!=0) memops are rejected with MemErr instead of issued.
module mem_access_stage #(
  parameter int WIDTH   = 64,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    ALUResultEx,
  input  logic [WIDTH-1:0]    RdData2ForMem,
  input  logic [REG_W-1:0]    WriteRegEX,
  input  logic [WIDTH-1:0]    LinkerRegisterDataEX,
  input  logic                MemToRegRegisterEX,
  input  logic                LinkerRegEX,
  input  logic                RegWriteRegisterEX,
  input  logic                MemWriteRegisterEX,
  input  logic                MemReadRegisterEX,
  mem_access_stage_if.master  mem,
  output logic                StallMEM,
  output logic [WIDTH-1:0]    DataMemWB,
  output logic [REG_W-1:0]    WriteRegMEM,
  output logic                RegWriteRegisterMEM,
  output logic                MemErr
);

  localparam int CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic             memop;
  logic [WIDTH-1:0] wbSel;

  assign memop    = MemReadRegisterEX | MemWriteRegisterEX;
  assign wbSel    = LinkerRegEX ? LinkerRegisterDataEX : ALUResultEx;
  // DONE deliberately does not stall: EX/MEM must advance past the op just completed.
  assign StallMEM = (state == WAIT) || ((state == IDLE) && memop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      waitCnt             <= '0;
      mem.mem_req         <= 1'b0;
      mem.mem_we          <= 1'b0;
      mem.mem_addr        <= '0;
      mem.mem_wdata       <= '0;
      DataMemWB           <= '0;
      WriteRegMEM         <= '0;
      RegWriteRegisterMEM <= 1'b0;
      MemErr              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!memop) begin
            DataMemWB           <= wbSel;
            WriteRegMEM         <= WriteRegEX;
            RegWriteRegisterMEM <= RegWriteRegisterEX;
`ifdef MEM_ALIGN_CHECK_EN
          end else if (|ALUResultEx[2:0]) begin
            MemErr              <= 1'b1;
            RegWriteRegisterMEM <= 1'b0;
            state               <= DONE;
`endif
          end else begin
            mem.mem_addr        <= ALUResultEx;
            mem.mem_wdata       <= RdData2ForMem;
            mem.mem_we          <= MemWriteRegisterEX;
            mem.mem_req         <= 1'b1;
            waitCnt             <= '0;
            RegWriteRegisterMEM <= 1'b0;
            state               <= WAIT;
          end
        end
        WAIT: begin
          // Ack is tested first so a last-cycle ack beats the timeout.
          if (mem.mem_ack) begin
            mem.mem_req         <= 1'b0;
            DataMemWB           <= MemToRegRegisterEX ? mem.mem_rdata : wbSel;
            WriteRegMEM         <= WriteRegEX;
            RegWriteRegisterMEM <= RegWriteRegisterEX;
            state               <= DONE;
          end else if (waitCnt == CNT_LAST) begin
            mem.mem_req         <= 1'b0;
            MemErr              <= 1'b1;
            RegWriteRegisterMEM <= 1'b0;
            state               <= DONE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DONE: begin
          RegWriteRegisterMEM <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a per-operation timeline model.
module tb_mem_access_stage;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] ALUResultEx, RdData2ForMem, LinkerRegisterDataEX;
  logic [RW-1:0] WriteRegEX;
  logic          MemToRegRegisterEX, LinkerRegEX, RegWriteRegisterEX;
  logic          MemWriteRegisterEX, MemReadRegisterEX;
  logic          StallMEM;
  logic [DW-1:0] DataMemWB;
  logic [RW-1:0] WriteRegMEM;
  logic          RegWriteRegisterMEM, MemErr;

  mem_access_stage_if #(.WIDTH(DW)) mif();

  mem_access_stage #(.WIDTH(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ALUResultEx          (ALUResultEx),
    .RdData2ForMem        (RdData2ForMem),
    .WriteRegEX           (WriteRegEX),
    .LinkerRegisterDataEX (LinkerRegisterDataEX),
    .MemToRegRegisterEX   (MemToRegRegisterEX),
    .LinkerRegEX          (LinkerRegEX),
    .RegWriteRegisterEX   (RegWriteRegisterEX),
    .MemWriteRegisterEX   (MemWriteRegisterEX),
    .MemReadRegisterEX    (MemReadRegisterEX),
    .mem                  (mif),
    .StallMEM             (StallMEM),
    .DataMemWB            (DataMemWB),
    .WriteRegMEM          (WriteRegMEM),
    .RegWriteRegisterMEM  (RegWriteRegisterMEM),
    .MemErr               (MemErr)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Expected registered outputs as of the most recent clock edge.
  logic [DW-1:0] expData, expAddr, expWdata;
  logic [RW-1:0] expWr;
  logic          expRw, expReq, expWe, expErr;
  logic [DW-1:0] lastRd;
  logic          useRdPattern = 1'b0;
  logic [DW-1:0] rdPattern = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    expData = '0; expAddr = '0; expWdata = '0; expWr = '0;
    expRw = 1'b0; expReq = 1'b0; expWe = 1'b0; expErr = 1'b0;
  endtask

  task automatic clearInputs();
    ALUResultEx = '0; RdData2ForMem = '0; LinkerRegisterDataEX = '0; WriteRegEX = '0;
    MemToRegRegisterEX = 1'b0; LinkerRegEX = 1'b0; RegWriteRegisterEX = 1'b0;
    MemWriteRegisterEX = 1'b0; MemReadRegisterEX = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
  endtask

  // One clock cycle, entered at posedge+1: drive ack/rdata, compare everything, advance past the next edge.
  task automatic cycle(input logic expStall, input logic ack,
                       output logic stallSeen, output logic reqSeen,
                       output logic [DW-1:0] dataSeen, output logic rwSeen);
    mif.mem_ack   = ack;
    mif.mem_rdata = useRdPattern ? rdPattern : {$urandom, $urandom};
    lastRd        = mif.mem_rdata;
    #1;
    chk("StallMEM",  {63'd0, StallMEM},            {63'd0, expStall});
    chk("mem_req",   {63'd0, mif.mem_req},         {63'd0, expReq});
    chk("mem_we",    {63'd0, mif.mem_we},          {63'd0, expWe});
    chk("mem_addr",  mif.mem_addr,                 expAddr);
    chk("mem_wdata", mif.mem_wdata,                expWdata);
    chk("MemErr",    {63'd0, MemErr},              {63'd0, expErr});
    chk("RegWrite",  {63'd0, RegWriteRegisterMEM}, {63'd0, expRw});
    if (expRw) begin
      chk("DataMemWB",   DataMemWB,            expData);
      chk("WriteRegMEM", {59'd0, WriteRegMEM}, {59'd0, expWr});
    end
    stallSeen = StallMEM;
    reqSeen   = mif.mem_req;
    dataSeen  = DataMemWB;
    rwSeen    = RegWriteRegisterMEM;
    @(posedge clk);
    #1;
  endtask

  // Presents one EX/MEM op and walks its whole timeline. lat = WAIT cycle (1..TO) carrying ack, 0 = never.
  task automatic run_op(input logic [DW-1:0] alu, input logic [DW-1:0] wd, input logic [DW-1:0] link,
                        input logic [RW-1:0] wr, input logic m2r, input logic lnk, input logic rw,
                        input logic mw, input logic mr, input int lat,
                        output int stallCnt, output int reqCnt,
                        output logic [DW-1:0] doneData, output logic doneRw);
    logic          memop, misal, acked, s, r, rwS;
    logic [DW-1:0] wbv, rdAtAck, dS;
    int            waits;
    ALUResultEx = alu; RdData2ForMem = wd; LinkerRegisterDataEX = link; WriteRegEX = wr;
    MemToRegRegisterEX = m2r; LinkerRegEX = lnk; RegWriteRegisterEX = rw;
    MemWriteRegisterEX = mw; MemReadRegisterEX = mr;
    memop = mw | mr;
    wbv   = lnk ? link : alu;
    misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (alu[2:0] != 3'b000);
`endif
    stallCnt = 0; reqCnt = 0; doneData = '0; doneRw = 1'b0; rdAtAck = '0;
    if (!memop) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), s, r, dS, rwS);
      stallCnt += int'(s); reqCnt += int'(r);
      expData = wbv; expWr = wr; expRw = rw;
    end else if (misal) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), s, r, dS, rwS);
      stallCnt += int'(s); reqCnt += int'(r);
      expErr = 1'b1; expRw = 1'b0;
      cycle(1'b0, 1'($urandom_range(0, 1)), s, r, doneData, doneRw);
      stallCnt += int'(s); reqCnt += int'(r);
      expRw = 1'b0;
    end else begin
      cycle(1'b1, 1'($urandom_range(0, 1)), s, r, dS, rwS);
      stallCnt += int'(s); reqCnt += int'(r);
      expReq = 1'b1; expWe = mw; expAddr = alu; expWdata = wd; expRw = 1'b0;
      acked = (lat >= 1) && (lat <= TO);
      waits = acked ? lat : TO;
      for (int k = 1; k <= waits; k++) begin
        cycle(1'b1, k == lat, s, r, dS, rwS);
        stallCnt += int'(s); reqCnt += int'(r);
        if (k == lat) rdAtAck = lastRd;
      end
      expReq = 1'b0;
      if (acked) begin
        expData = m2r ? rdAtAck : wbv; expWr = wr; expRw = rw;
      end else begin
        expErr = 1'b1; expRw = 1'b0;
      end
      cycle(1'b0, 1'($urandom_range(0, 1)), s, r, doneData, doneRw);
      stallCnt += int'(s); reqCnt += int'(r);
      expRw = 1'b0;
    end
  endtask

  initial begin
    int            sc, rc, lat, kind;
    logic [DW-1:0] dd, addr;
    logic          drw;

    clearInputs();
    resetModel();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_StallMEM",  {63'd0, StallMEM},            64'd0);
    chk("rst_mem_req",   {63'd0, mif.mem_req},         64'd0);
    chk("rst_mem_we",    {63'd0, mif.mem_we},          64'd0);
    chk("rst_mem_addr",  mif.mem_addr,                 64'd0);
    chk("rst_mem_wdata", mif.mem_wdata,                64'd0);
    chk("rst_DataMemWB", DataMemWB,                    64'd0);
    chk("rst_WriteReg",  {59'd0, WriteRegMEM},         64'd0);
    chk("rst_RegWrite",  {63'd0, RegWriteRegisterMEM}, 64'd0);
    chk("rst_MemErr",    {63'd0, MemErr},              64'd0);
    reset = 1'b1;

    run_op(64'd16, 64'd0, 64'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, sc, rc, dd, drw);
    #1;
    chk("alu_DataMemWB", DataMemWB,                    64'd16);
    chk("alu_WriteReg",  {59'd0, WriteRegMEM},         64'd3);
    chk("alu_RegWrite",  {63'd0, RegWriteRegisterMEM}, 64'd1);
    chk("alu_stall",     64'(sc),                      64'd0);

    run_op(64'd7, 64'd0, 64'd104, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, sc, rc, dd, drw);
    #1;
    chk("link_DataMemWB", DataMemWB, 64'd104);

    useRdPattern = 1'b1; rdPattern = 64'hDEAD;
    run_op(64'd40, 64'd0, 64'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, sc, rc, dd, drw);
    useRdPattern = 1'b0;
    chk("load_stall",     64'(sc),      64'd4);
    chk("load_req",       64'(rc),      64'd3);
    chk("load_done_data", dd,           64'hDEAD);
    chk("load_done_rw",   {63'd0, drw}, 64'd1);
    #1;
    chk("load_bubble", {63'd0, RegWriteRegisterMEM}, 64'd0);

    run_op(64'd8, 64'd99, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, sc, rc, dd, drw);
    chk("store_req",   64'(rc), 64'd1);
    chk("store_stall", 64'(sc), 64'd2);

`ifdef MEM_ALIGN_CHECK_EN
    run_op(64'd5, 64'd0, 64'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, sc, rc, dd, drw);
    chk("align_stall",  64'(sc),          64'd1);
    chk("align_req",    64'(rc),          64'd0);
    chk("align_MemErr", {63'd0, MemErr},  64'd1);
`endif

    run_op(64'd32, 64'd0, 64'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, TO, sc, rc, dd, drw);
    chk("lastack_req", 64'(rc),      64'd16);
    chk("lastack_rw",  {63'd0, drw}, 64'd1);

    run_op(64'd48, 64'd0, 64'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, sc, rc, dd, drw);
    chk("timeout_req",    64'(rc),         64'd16);
    chk("timeout_stall",  64'(sc),         64'd17);
    chk("timeout_MemErr", {63'd0, MemErr}, 64'd1);
    chk("timeout_rw",     {63'd0, drw},    64'd0);

    // Asynchronous reset while a request is outstanding.
    ALUResultEx = 64'd64; MemReadRegisterEX = 1'b1; mif.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("midwait_req_before", {63'd0, mif.mem_req}, 64'd1);
    reset = 1'b0;
    #1;
    chk("midwait_req_after",  {63'd0, mif.mem_req}, 64'd0);
    chk("midwait_MemErr",     {63'd0, MemErr},      64'd0);
    clearInputs();
    resetModel();
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) addr[2:0] = 3'b000;
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
      run_op(addr, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             (kind == 2) || (kind == 3), (kind == 1) || (kind == 3), lat, sc, rc, dd, drw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage; consumes the EX/MEM register outputs and produces the MEM/WB register.
- Drives a variable-latency request/acknowledge data-memory port and stalls upstream stages while an access is outstanding.
- Its registered write-back value, DataMemWB, is the MEM-stage forwarding source fed back to the EX operand muxes.

Parameters:
- WIDTH, 64, data/address width.
- REG_W, 5, destination register ID width.
- TIMEOUT, 16, WAIT cycles without mem_ack before the access is aborted.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- ALUResultEx  in  WIDTH  ALU result / memory address from EX.
- RdData2ForMem  in  WIDTH  store data from EX.
- WriteRegEX  in  REG_W  destination register.
- LinkerRegisterDataEX  in  WIDTH  PC+4 for link writes.
- MemToRegRegisterEX, LinkerRegEX, RegWriteRegisterEX  in  1 each  WB controls.
- MemWriteRegisterEX, MemReadRegisterEX  in  1 each  memory controls.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store.
- mem_addr  out  WIDTH  access address.
- mem_wdata  out  WIDTH  store data.
- mem_ack  in  1  access complete; valid only while mem_req=1.
- mem_rdata  in  WIDTH  load data, valid in the mem_ack cycle.
- StallMEM  out  1  upstream hold request, combinational.
- DataMemWB  out  WIDTH  registered write-back data.
- WriteRegMEM  out  REG_W  registered destination register.
- RegWriteRegisterMEM  out  1  registered write enable.
- MemErr  out  1  sticky error flag.

Behaviour:
- memop = MemReadRegisterEX | MemWriteRegisterEX. If both are set, treat the access as a store.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, timeout counter 0. An asynchronous reset during WAIT drops mem_req in the same instant.
- IDLE, memop=0, one-cycle latency:
  - DataMemWB <= LinkerRegEX ? LinkerRegisterDataEX : ALUResultEx.
  - WriteRegMEM <= WriteRegEX; RegWriteRegisterMEM <= RegWriteRegisterEX.
  - StallMEM=0.
- IDLE, memop=1:
  - StallMEM=1 combinationally.
  - At the edge: latch mem_addr=ALUResultEx, mem_wdata=RdData2ForMem, mem_we=MemWriteRegisterEX; mem_req<=1; counter<=0; go to WAIT.
  - MEM/WB loads a bubble (RegWriteRegisterMEM<=0).
- WAIT:
  - StallMEM=1; mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - MEM/WB holds its value.
  - The counter increments each cycle without ack.
- WAIT, mem_ack=1:
  - mem_req<=0.
  - DataMemWB <= MemToReg ? mem_rdata : (Linker ? PC+4 : ALUResultEx).
  - WriteRegMEM and RegWriteRegisterMEM load from the EX inputs, which are still held by the stall.
  - Go to DONE.
- WAIT, counter reaches TIMEOUT-1 without ack:
  - mem_req<=0; MemErr<=1; RegWriteRegisterMEM<=0; go to DONE.
  - An ack arriving in that same cycle wins over the timeout.
- DONE:
  - StallMEM=0, so EX/MEM advances on this edge.
  - The completed op is not re-issued, even though memop is still visible.
  - MEM/WB keeps the ack result for exactly this cycle, then loads a bubble at the edge; go to IDLE.
- Minimum memory op cost: ack in the first WAIT cycle gives 2 stall cycles (IDLE-detect, WAIT).
- mem_ack is ignored in IDLE and DONE.
- MemErr clears only on reset.
- Back-to-back memory ops: after DONE, the next op is detected in IDLE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, a memop with ALUResultEx[2:0]!=0 issues no mem_req.
  - It stalls exactly one cycle (IDLE-detect), sets MemErr, then goes IDLE->DONE with RegWriteRegisterMEM=0.
- When undefined, addresses pass unchecked and misaligned accesses are issued normally.

Test Plan:
- Reset and ALU op:
  - Stimulus: reset=0, then release; ALUResultEx=64'd16, RegWrite=1, WriteRegEX=5'd3.
  - Required: after reset all outputs are 0. After 1 edge, DataMemWB=16, WriteRegMEM=3, RegWriteRegisterMEM=1, StallMEM never 1.
- Link write:
  - Stimulus: LinkerRegEX=1, LinkerRegisterDataEX=64'd104, ALUResultEx=64'd7.
  - Required: DataMemWB=104 after 1 edge.
- Load with 3-cycle ack:
  - Stimulus: MemRead=1, MemToReg=1, addr=64'd40; ack with mem_rdata=64'hDEAD on the 3rd WAIT cycle.
  - Required: mem_req=1 and mem_addr=40 for 3 cycles; StallMEM=1 for 4 cycles. In DONE, DataMemWB=64'hDEAD and RegWriteRegisterMEM=1; it is a bubble the cycle after.
- Store, immediate ack:
  - Stimulus: MemWrite=1, addr=64'd8, RdData2ForMem=64'd99.
  - Required: mem_we=1, mem_wdata=99, one request cycle, no re-issue in DONE.
- Timeout and reset:
  - Stimulus: MemRead, ack never asserted.
  - Required: mem_req falls after 16 WAIT cycles; MemErr=1; RegWriteRegisterMEM=0. Pulling reset low mid-WAIT clears mem_req and MemErr asynchronously.
- Alignment check (MEM_ALIGN_CHECK_EN defined):
  - Stimulus: MemRead with addr=64'd5.
  - Required: no mem_req, MemErr=1, one stall cycle.
